mux_nto1_reg: RTL and testbench
===============================

# mux_nto1_reg

Parametrised, registered N-to-1 word multiplexer with valid/ready handshake. It is the pipelined successor of the ALU's 16-bit 2:1 operand mux. It supports any input count and word width, and offers an auto-scan mode that steps through the inputs round-robin. It sits between the register-read stage and the ALU operand latches and adds one pipeline stage.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- NIN, 4, number of data inputs (≥2, need not be a power of two)
- SEL_W, $clog2(NIN), select width (derived; do not override)

Ports:
- clkpos  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NIN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  input select, used when mode=0
- mode  input  1  0 = explicit select, 1 = auto-scan
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index actually used for out_data
- out_err  output  1  out_data came from an out-of-range select
- out_valid  output  1  out_data/out_sel/out_err valid
- out_ready  input  1  downstream accepts output

## Operation
- in_ready = !out_valid || out_ready (combinational). This gives a single output register and a full-throughput pass-through.
- Accept happens when in_valid && in_ready.
- On accept, the effective index eff is:
  - mode=0: eff = in_sel
  - mode=1: eff = scan_ptr
- On accept, the output register is loaded as follows:
  - out_valid ← 1
  - out_sel ← eff
  - if eff < NIN: out_data ← word eff, out_err ← 0
  - else: out_data ← 0, out_err ← 1. This case can only occur in mode 0 with NIN not a power of two.
- When out_valid && out_ready and there is no accept in the same cycle, out_valid ← 0. out_data, out_sel and out_err hold their last values.
- Simultaneous drain and accept: the register reloads and out_valid stays 1. There is no bubble.
- Stall (out_valid && !out_ready): all output fields are held stable. in_ready is 0.
- scan_ptr (SEL_W bits, internal) behaviour:
  - increments on each accept while mode=1
  - wraps from NIN-1 to 0
  - is unchanged by accepts in mode=0
  - retains its value across mode changes
- mode and in_sel are sampled only on accept. Changing them while no accept occurs has no effect.
- Input data is captured on the accept edge. Later changes on in_data do not affect the held output.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - out_valid=0, out_data=0, out_sel=0, out_err=0
  - scan_ptr=0
  - out_par=0 when configured
- in_ready=1 during and after reset, because out_valid=0.
- A request is accepted at edge N and the result appears with out_valid=1 after edge N. Latency is 1 cycle.
- Throughput is 1 word per cycle while out_ready=1.
- Reset asserted mid-transfer: the pending output is discarded and scan_ptr returns to 0. The first accept after release uses index 0 in mode 1.
- All state updates occur on the rising edge of clkpos. No combinational path exists from in_data to out_data.

## Configuration
- MUX_NTO1_REG_PARITY_EN defined:
  - adds output port out_par (1 bit), registered together with out_data
  - out_par = ^ of the loaded out_data word, i.e. even parity over the word: the XOR of out_data bits and out_par is 0
  - out_par is 0 when out_err=1, because the data is 0
  - out_par resets to 0
- Not defined: the out_par port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset/idle: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_sel=0, in_ready=1. Release, then mode=0, in_sel=2, words 0x1111/0x2222/0x3333/0x4444 -> next cycle out_data=0x3333, out_sel=2, out_valid=1.
- Back-to-back stream: mode=0, out_ready=1, sel sequence 0,1,2,3 on consecutive cycles -> out_data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with no gap.
- Backpressure: out_ready=0 for 3 cycles after a load of 0x2222 -> out_data held at 0x2222 and in_ready=0 throughout. Raise out_ready together with a new request (sel=3) -> out_data=0x4444 the next cycle and out_valid stays 1.
- Auto-scan wrap: NIN=3, mode=1, 5 accepts -> out_sel 0,1,2,0,1. Switch to mode=0 with sel=0 for 1 accept, then return to mode=1 -> next out_sel=2.
- Out-of-range: NIN=3, mode=0, in_sel=3 -> out_data=0, out_err=1, out_sel=3. The next valid select clears out_err.
- Reset mid-scan, plus parity (MUX_NTO1_REG_PARITY_EN): after 2 scan accepts, pulse rst_n low asynchronously between edges -> outputs clear immediately and the next accept gives out_sel=0. Word 0x0007 -> out_par=1. Word 0x0003 -> out_par=0.

Source files
------------

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 word multiplexer with valid/ready handshake and an
// auto-scan (round-robin) mode. Adds one pipeline stage between register
// read and the ALU operand latches.
// Optional feature: define MUX_NTO1_REG_PARITY_EN to add out_par, an even
// parity bit registered alongside out_data.
module mux_nto1_reg #(
    parameter int WIDTH = 16,
    parameter int NIN   = 4,
    parameter int SEL_W = $clog2(NIN)
) (
    input  logic                 clkpos,
    input  logic                 rst_n,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_err,
`ifdef MUX_NTO1_REG_PARITY_EN
    output logic                 out_par,
`endif
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Index is legal only when it addresses one of the NIN inputs; with a
    // non-power-of-two NIN the select field can encode unused indices.
    function automatic logic sel_in_range(input logic [SEL_W-1:0] idx);
        return (int'(idx) < NIN);
    endfunction

    // Word lookup; out-of-range indices yield zero.
    function automatic logic [WIDTH-1:0] pick_word(input logic [NIN*WIDTH-1:0] d,
                                                   input logic [SEL_W-1:0]     idx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < NIN; k++) begin
            if (idx == SEL_W'(k)) w = d[k*WIDTH +: WIDTH];
        end
        return w;
    endfunction

    // Round-robin successor of the scan pointer, wrapping at NIN-1.
    function automatic logic [SEL_W-1:0] next_scan(input logic [SEL_W-1:0] p);
        if (p == SEL_W'(NIN - 1)) return '0;
        return p + SEL_W'(1);
    endfunction

    logic [WIDTH-1:0] data_p0;
    logic [SEL_W-1:0] sel_p0;
    logic             err_p0;
    logic             vld_p0;
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] eff;
    logic             accept;

    assign in_ready = !vld_p0 || out_ready;
    assign accept   = in_valid && in_ready;

    // Effective index: explicit select or the round-robin pointer.
    always_comb begin
        eff = in_sel;
        if (mode) eff = scan_ptr;
    end

    // Stage p0: output register, loaded on accept, cleared of valid on drain.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            data_p0 <= '0;
            sel_p0  <= '0;
            err_p0  <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            sel_p0  <= eff;
            err_p0  <= !sel_in_range(eff);
            data_p0 <= pick_word(in_data, eff);
        end else if (vld_p0 && out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    // Scan pointer advances only on accepts made in auto-scan mode.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr <= '0;
        end else if (accept && mode) begin
            scan_ptr <= next_scan(scan_ptr);
        end
    end

`ifdef MUX_NTO1_REG_PARITY_EN
    logic par_p0;

    // Even parity of the word being loaded; zero data gives zero parity.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            par_p0 <= 1'b0;
        end else if (accept) begin
            par_p0 <= ^pick_word(in_data, eff);
        end
    end

    assign out_par = par_p0;
`endif

    assign out_data  = data_p0;
    assign out_sel   = sel_p0;
    assign out_err   = err_p0;
    assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: a 4-input instance for streaming and
// backpressure, and a 3-input instance for scan wrap, out-of-range select,
// asynchronous reset and (when enabled) parity.
module tb_mux_nto1_reg;

    logic        clkpos;
    logic        rst_n;
    logic [63:0] din4;
    logic [47:0] din3;
    logic [1:0]  in_sel;
    logic        mode;
    logic        in_valid;
    logic        out_ready;

    logic        rdy4, err4, vld4;
    logic [15:0] dat4;
    logic [1:0]  sel4;
    logic        rdy3, err3, vld3;
    logic [15:0] dat3;
    logic [1:0]  sel3;
`ifdef MUX_NTO1_REG_PARITY_EN
    logic        par4, par3;
`endif

    int total = 0;
    int bad   = 0;

    mux_nto1_reg #(.WIDTH(16), .NIN(4)) u4 (
        .clkpos(clkpos), .rst_n(rst_n), .in_data(din4), .in_sel(in_sel),
        .mode(mode), .in_valid(in_valid), .in_ready(rdy4), .out_data(dat4),
        .out_sel(sel4), .out_err(err4),
`ifdef MUX_NTO1_REG_PARITY_EN
        .out_par(par4),
`endif
        .out_valid(vld4), .out_ready(out_ready)
    );

    mux_nto1_reg #(.WIDTH(16), .NIN(3)) u3 (
        .clkpos(clkpos), .rst_n(rst_n), .in_data(din3), .in_sel(in_sel),
        .mode(mode), .in_valid(in_valid), .in_ready(rdy3), .out_data(dat3),
        .out_sel(sel3), .out_err(err3),
`ifdef MUX_NTO1_REG_PARITY_EN
        .out_par(par3),
`endif
        .out_valid(vld3), .out_ready(out_ready)
    );

    initial begin
        clkpos = 1'b0;
        forever #5 clkpos = ~clkpos;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clkpos);
        #1;
    endtask

    task automatic drive(input logic md, input logic [1:0] s, input logic v, input logic r);
        mode      = md;
        in_sel    = s;
        in_valid  = v;
        out_ready = r;
    endtask

    typedef struct {
        logic        md;
        logic [1:0]  sel;
        logic        vld;
        logic        rdy;
        logic [15:0] e_data;
        logic [1:0]  e_sel;
        logic        e_vld;
        logic        e_inr;
    } vec_t;

    vec_t vt[12];

    initial begin
        // Stream, drain, backpressure and release-with-new-request on u4.
        vt[0]  = '{1'b0, 2'd2, 1'b1, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 16'h1111, 2'd0, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 2'd1, 1'b1, 1'b1, 16'h2222, 2'd1, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 2'd2, 1'b1, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 2'd3, 1'b1, 1'b1, 16'h4444, 2'd3, 1'b1, 1'b1};
        vt[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h4444, 2'd3, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 2'd2, 1'b1, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 2'd3, 1'b1, 1'b1, 16'h4444, 2'd3, 1'b1, 1'b1};
        vt[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h4444, 2'd3, 1'b0, 1'b1};

        // Reset with random inputs on everything.
        rst_n     = 1'b1;
        din4      = {$urandom, $urandom};
        din3      = {$urandom, $urandom};
        drive(1'($urandom), 2'($urandom), 1'b1, 1'($urandom));
        #1 rst_n  = 1'b0;
        step(); step(); step();
        chk("rst_vld", 32'(vld4), 32'd0);
        chk("rst_data", 32'(dat4), 32'd0);
        chk("rst_sel", 32'(sel4), 32'd0);
        chk("rst_err", 32'(err4), 32'd0);
        chk("rst_inr", 32'(rdy4), 32'd1);
        chk("rst_vld3", 32'(vld3), 32'd0);

        din4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        din3 = {16'h3333, 16'h2222, 16'h1111};
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        chk("idle_inr", 32'(rdy4), 32'd1);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].md, vt[i].sel, vt[i].vld, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_data", i), 32'(dat4), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_sel", i), 32'(sel4), 32'(vt[i].e_sel));
            chk($sformatf("vec%0d_vld", i), 32'(vld4), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d_inr", i), 32'(rdy4), 32'(vt[i].e_inr));
            chk($sformatf("vec%0d_err", i), 32'(err4), 32'd0);
        end

        // Held data must not follow later input changes.
        din4 = {16'hdead, 16'hbeef, 16'hcafe, 16'hf00d};
        step();
        chk("hold_after_din", 32'(dat4), 32'h4444);
        din4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Auto-scan wrap on u3 (pointer still 0: earlier accepts were mode 0).
        for (int i = 0; i < 5; i++) begin
            logic [1:0]  es;
            logic [15:0] ed;
            es = 2'(i % 3);
            ed = 16'h1111 * 16'(es + 2'd1);
            drive(1'b1, 2'd3, 1'b1, 1'b1);
            step();
            chk($sformatf("scan%0d_sel", i), 32'(sel3), 32'(es));
            chk($sformatf("scan%0d_data", i), 32'(dat3), 32'(ed));
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        step();
        chk("scan_m0_sel", 32'(sel3), 32'd0);
        drive(1'b1, 2'd1, 1'b1, 1'b1);
        step();
        chk("scan_resume_sel", 32'(sel3), 32'd2);
        chk("scan_resume_data", 32'(dat3), 32'h3333);

        // Out-of-range select on the 3-input instance.
        drive(1'b0, 2'd3, 1'b1, 1'b1);
        step();
        chk("oor_data", 32'(dat3), 32'd0);
        chk("oor_err", 32'(err3), 32'd1);
        chk("oor_sel", 32'(sel3), 32'd3);
        chk("oor_vld", 32'(vld3), 32'd1);
`ifdef MUX_NTO1_REG_PARITY_EN
        chk("oor_par", 32'(par3), 32'd0);
`endif
        drive(1'b0, 2'd1, 1'b1, 1'b1);
        step();
        chk("oor_clear_err", 32'(err3), 32'd0);
        chk("oor_clear_data", 32'(dat3), 32'h2222);

        // Reset mid-scan: pointer is 0 here; two scan accepts move it to 2.
        drive(1'b1, 2'd0, 1'b1, 1'b1);
        step();
        step();
        chk("pre_rst_sel", 32'(sel3), 32'd1);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(vld3), 32'd0);
        chk("async_rst_sel", 32'(sel3), 32'd0);
        chk("async_rst_data", 32'(dat3), 32'd0);
        chk("async_rst_inr", 32'(rdy3), 32'd1);
        #2 rst_n = 1'b1;
        drive(1'b1, 2'd2, 1'b1, 1'b1);
        step();
        chk("post_rst_sel", 32'(sel3), 32'd0);
        chk("post_rst_data", 32'(dat3), 32'h1111);

`ifdef MUX_NTO1_REG_PARITY_EN
        din3 = {16'h3333, 16'h2222, 16'h0007};
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        step();
        chk("par_7", 32'(par3), 32'd1);
        din3 = {16'h3333, 16'h2222, 16'h0003};
        step();
        chk("par_3", 32'(par3), 32'd0);
        drive(1'b0, 2'd3, 1'b1, 1'b1);
        step();
        chk("par_4444", 32'(par4), 32'd0);
`endif

        drive(1'b0, 2'd0, 1'b0, 1'b1);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
